// File: rtl/rope_scheduler.sv
// rope_scheduler: horizontal swing scheduler for a rope sprite.
// The rope's left edge swings between MIN_X and MAX_X while its right edge
// stays fixed, holding DWELL_FRAMES frames at each turnaround. Motion
// advances only on startOfFrame pulses.
// Ports:
//   clk          - system clock, rising edge
//   resetN       - synchronous reset, active-high despite the name
//   startOfFrame - one-cycle pulse per video frame
//   enable       - 1 = rope runs, 0 = rope parks in IDLE
//   freeze       - 1 = player hanging on rope; motion and counting suspended
//   speed_sel    - speed code 0..3 = 32/64/128/256 units/frame (128 = 1 px)
//   topLeftX     - rope left edge, pixels
//   topLeftY     - rope top, pixels (constant)
//   widthX       - rope width, pixels
//   moving       - 1 while swinging and not frozen
//   dir_right    - 1 when the current or next swing is rightward
module rope_scheduler #(
  parameter int INITIAL_X     = 450,
  parameter int INITIAL_Y     = 226,
  parameter int INITIAL_WIDTH = 123,
  parameter int MIN_X         = 400,
  parameter int MAX_X         = 544,
  parameter int DWELL_FRAMES  = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               freeze,
  input  logic [1:0]         speed_sel,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic signed [10:0] widthX,
  output logic               moving,
  output logic               dir_right
);

  typedef enum logic [2:0] {IDLE, SWING_R, DWELL_R, SWING_L, DWELL_L} state_t;

  localparam logic signed [31:0] POS_INIT   = 32'(INITIAL_X * 128);
  localparam logic signed [31:0] POS_MIN    = 32'(MIN_X * 128);
  localparam logic signed [31:0] POS_MAX    = 32'(MAX_X * 128);
  localparam logic signed [10:0] RIGHT_EDGE = 11'(INITIAL_X + INITIAL_WIDTH);
  localparam logic [15:0]        DWELL_LAST = 16'(DWELL_FRAMES - 1);

  state_t             r_state;
  logic signed [31:0] r_pos;
  logic signed [31:0] r_speed;
  logic [15:0]        r_dwell;
  logic signed [10:0] r_topLeftX;
  logic signed [10:0] r_widthX;
  logic               r_moving;
  logic               r_dir_right;

  logic               w_tick;
  logic signed [31:0] w_speed_new;
  logic signed [31:0] w_pos_add;
  logic signed [31:0] w_pos_sub;
  logic signed [31:0] w_pos_nx;
  logic signed [10:0] w_x_nx;

  assign w_tick      = startOfFrame && enable && !freeze;
  assign w_speed_new = 32'sd32 <<< speed_sel;
  assign w_pos_add   = r_pos + r_speed;
  assign w_pos_sub   = r_pos - r_speed;

  // Next position is resolved combinationally so the registered pixel
  // outputs can be loaded from it on the same edge as the state update.
  always_comb begin
    w_pos_nx = r_pos;
    if (resetN) begin
      w_pos_nx = POS_INIT;
    end else if (w_tick) begin
      case (r_state)
        SWING_R: w_pos_nx = (w_pos_add >= POS_MAX) ? POS_MAX : w_pos_add;
        SWING_L: w_pos_nx = (w_pos_sub <= POS_MIN) ? POS_MIN : w_pos_sub;
        default: w_pos_nx = r_pos;
      endcase
    end
  end

  assign w_x_nx = 11'(w_pos_nx >>> 7);

  always_ff @(posedge clk) begin
    r_pos      <= w_pos_nx;
    r_topLeftX <= w_x_nx;
    r_widthX   <= RIGHT_EDGE - w_x_nx;
    if (resetN) begin
      r_state     <= IDLE;
      r_dwell     <= '0;
      r_speed     <= 32'sd128;
      r_dir_right <= 1'b1;
      r_moving    <= 1'b0;
    end else if (!enable) begin
      r_state     <= IDLE;
      r_dir_right <= 1'b1;
      r_moving    <= 1'b0;
    end else if (freeze) begin
      r_moving <= 1'b0;
    end else if (startOfFrame) begin
      case (r_state)
        IDLE: begin
          r_state     <= SWING_R;
          r_speed     <= w_speed_new;
          r_dir_right <= 1'b1;
          r_moving    <= 1'b1;
        end
        SWING_R: begin
          if (w_pos_add >= POS_MAX) begin
            r_state  <= DWELL_R;
            r_dwell  <= '0;
            r_moving <= 1'b0;
          end else begin
            r_moving <= 1'b1;
          end
        end
        SWING_L: begin
          if (w_pos_sub <= POS_MIN) begin
            r_state  <= DWELL_L;
            r_dwell  <= '0;
            r_moving <= 1'b0;
          end else begin
            r_moving <= 1'b1;
          end
        end
        DWELL_R: begin
          if (r_dwell == DWELL_LAST) begin
            r_state     <= SWING_L;
            r_speed     <= w_speed_new;
            r_dir_right <= 1'b0;
            r_moving    <= 1'b1;
          end else begin
            r_dwell  <= r_dwell + 16'd1;
            r_moving <= 1'b0;
          end
        end
        DWELL_L: begin
          if (r_dwell == DWELL_LAST) begin
            r_state     <= SWING_R;
            r_speed     <= w_speed_new;
            r_dir_right <= 1'b1;
            r_moving    <= 1'b1;
          end else begin
            r_dwell  <= r_dwell + 16'd1;
            r_moving <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end else begin
      // Between frames only the freeze-dependent moving flag can change.
      r_moving <= (r_state == SWING_R) || (r_state == SWING_L);
    end
  end

  assign topLeftX  = r_topLeftX;
  assign topLeftY  = 11'(INITIAL_Y);
  assign widthX    = r_widthX;
  assign moving    = r_moving;
  assign dir_right = r_dir_right;

endmodule

// File: tb/tb_rope_scheduler.sv
// tb_rope_scheduler: self-checking bench for rope_scheduler (default params).
module tb_rope_scheduler;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              enable;
  logic              freeze;
  logic [1:0]        speed_sel;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic signed [10:0] widthX;
  logic              moving;
  logic              dir_right;

  always #5 clk = ~clk;

  rope_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .freeze       (freeze),
    .speed_sel    (speed_sel),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .widthX       (widthX),
    .moving       (moving),
    .dir_right    (dir_right)
  );

  localparam int RIGHT = 573;
  localparam int PMAX  = 544 * 128;
  localparam int PMIN  = 400 * 128;
  localparam int DWELL = 15;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position in 1/128 px, remaining hold frames at a
  // turnaround (0 = swinging), direction as a sign.
  int m_pos  = 450 * 128;
  int m_hold = 0;
  int m_spd  = 128;
  int m_dir  = 1;
  bit m_run  = 0;
  bit m_mv   = 0;

  task automatic model_step();
    if (resetN) begin
      m_run = 0; m_pos = 450 * 128; m_hold = 0; m_spd = 128; m_dir = 1; m_mv = 0;
    end else if (!enable) begin
      m_run = 0; m_hold = 0; m_dir = 1; m_mv = 0;
    end else if (freeze) begin
      m_mv = 0;
    end else if (startOfFrame) begin
      if (!m_run) begin
        m_run = 1; m_spd = 32 * (1 << speed_sel); m_dir = 1; m_mv = 1;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_dir = -m_dir; m_spd = 32 * (1 << speed_sel); m_mv = 1;
        end else begin
          m_mv = 0;
        end
      end else begin
        m_pos += m_dir * m_spd;
        if (m_pos >= PMAX) begin m_pos = PMAX; m_hold = DWELL; end
        if (m_pos <= PMIN) begin m_pos = PMIN; m_hold = DWELL; end
        m_mv = (m_hold == 0);
      end
    end else begin
      m_mv = m_run && (m_hold == 0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int x, input int w, input int mv, input int dr);
    chk({name, "_x"},   int'(topLeftX), x);
    chk({name, "_w"},   int'(widthX), w);
    chk({name, "_mv"},  int'(moving), mv);
    chk({name, "_dir"}, int'(dir_right), dr);
  endtask

  task automatic chk_model(input string name);
    chk_out(name, m_pos / 128, RIGHT - m_pos / 128, int'(m_mv), (m_dir > 0) ? 1 : 0);
  endtask

  task automatic reset_dut();
    resetN = 1'b1; enable = 1'b0; freeze = 1'b0; startOfFrame = 1'b0; speed_sel = 2'd0;
    tick();
    tick();
    resetN = 1'b0;
  endtask

  typedef struct {
    bit       rst, en, fr, sof;
    bit [1:0] spd;
    int       x, w;
    bit       mv, dir;
  } vec_t;

  vec_t tbl[17];

  initial begin
    resetN = 1'b1; enable = 1'b0; freeze = 1'b0; startOfFrame = 1'b0; speed_sel = 2'd0;

    tbl[0]  = '{1, 0, 0, 0, 2'd0, 450, 123, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 2'd0, 450, 123, 0, 1};
    tbl[2]  = '{0, 1, 0, 1, 2'd2, 450, 123, 1, 1};
    tbl[3]  = '{0, 1, 0, 1, 2'd0, 451, 122, 1, 1};
    tbl[4]  = '{0, 1, 1, 1, 2'd0, 451, 122, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 2'd0, 451, 122, 1, 1};
    tbl[6]  = '{0, 1, 0, 1, 2'd3, 452, 121, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 2'd3, 452, 121, 0, 1};
    tbl[8]  = '{0, 1, 0, 1, 2'd3, 452, 121, 1, 1};
    tbl[9]  = '{0, 1, 0, 1, 2'd0, 454, 119, 1, 1};
    tbl[10] = '{0, 0, 1, 1, 2'd0, 454, 119, 0, 1};
    tbl[11] = '{1, 1, 0, 1, 2'd0, 450, 123, 0, 1};
    tbl[12] = '{0, 1, 0, 1, 2'd0, 450, 123, 1, 1};
    tbl[13] = '{0, 1, 0, 1, 2'd0, 450, 123, 1, 1};
    tbl[14] = '{0, 1, 0, 1, 2'd0, 450, 123, 1, 1};
    tbl[15] = '{0, 1, 0, 1, 2'd0, 450, 123, 1, 1};
    tbl[16] = '{0, 1, 0, 1, 2'd0, 451, 122, 1, 1};

    tick();
    chk_out("reset", 450, 123, 0, 1);
    chk("reset_y", int'(topLeftY), 226);

    for (int i = 0; i < 17; i++) begin
      resetN = tbl[i].rst; enable = tbl[i].en; freeze = tbl[i].fr;
      startOfFrame = tbl[i].sof; speed_sel = tbl[i].spd;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].x, tbl[i].w, int'(tbl[i].mv), int'(tbl[i].dir));
    end
    startOfFrame = 1'b0;

    // Full right swing at speed 2, dwell, and first leftward step.
    reset_dut();
    enable = 1'b1; speed_sel = 2'd2;
    frame();
    chk_out("enter", 450, 123, 1, 1);
    repeat (93) frame();
    chk_out("swing93", 543, 30, 1, 1);
    frame();
    chk_out("dwellR", 544, 29, 0, 1);
    repeat (14) frame();
    chk_out("dwell14", 544, 29, 0, 1);
    frame();
    chk_out("leaveR", 544, 29, 1, 0);
    frame();
    chk_out("firstL", 543, 30, 1, 0);

    // Speed 3 reaches exactly 544 without overshoot.
    reset_dut();
    enable = 1'b1; speed_sel = 2'd3;
    frame();
    for (int k = 1; k <= 47; k++) begin
      frame();
      chk($sformatf("fast%0d_x", k), int'(topLeftX), 450 + 2 * k);
    end
    chk("fast_clamp_mv", int'(moving), 0);
    frame();
    chk("fast_hold_x", int'(topLeftX), 544);

    // Into DWELL_L, then a reset pulse.
    repeat (14) frame();
    chk_out("fast_leaveR", 544, 29, 1, 0);
    repeat (72) frame();
    chk_out("dwellL", 400, 173, 0, 0);
    repeat (3) frame();
    resetN = 1'b1;
    tick();
    chk_out("rst_dwellL", 450, 123, 0, 1);
    resetN = 1'b0;

    // Freeze mid-swing at 500.
    reset_dut();
    enable = 1'b1; speed_sel = 2'd2;
    frame();
    repeat (50) frame();
    chk_out("pre_freeze", 500, 73, 1, 1);
    freeze = 1'b1;
    for (int k = 0; k < 20; k++) begin
      frame();
      chk($sformatf("frz%0d_x", k), int'(topLeftX), 500);
      chk($sformatf("frz%0d_mv", k), int'(moving), 0);
    end
    freeze = 1'b0;
    frame();
    chk_out("unfreeze", 501, 72, 1, 1);

    // Enable drop at 520, then restart.
    repeat (19) frame();
    enable = 1'b0;
    tick();
    chk_out("disable", 520, 53, 0, 1);
    repeat (3) frame();
    chk_out("parked", 520, 53, 0, 1);
    enable = 1'b1;
    frame();
    chk_out("restart", 520, 53, 1, 1);
    frame();
    chk_out("restart_step", 521, 52, 1, 1);

    // Randomised traffic against the reference model.
    reset_dut();
    for (int c = 0; c < 6000; c++) begin
      resetN       = ($urandom_range(0, 499) == 0);
      enable       = ($urandom_range(0, 63) != 0);
      freeze       = ($urandom_range(0, 7) == 0);
      startOfFrame = ($urandom_range(0, 2) == 0);
      speed_sel    = 2'($urandom_range(0, 3));
      tick();
      chk_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rope_scheduler.md
ROPE_SCHEDULER -- requirements
Module: rope_scheduler

Interface
REQ-001 Parameter INITIAL_X, default 450, rope top-left X in pixels after reset.
REQ-002 Parameter INITIAL_Y, default 226, constant rope top-left Y in pixels.
REQ-003 Parameter INITIAL_WIDTH, default 123, rope width in pixels after reset.
REQ-004 Parameter MIN_X, default 400, left turnaround X in pixels.
REQ-005 Parameter MAX_X, default 544, right turnaround X in pixels.
REQ-006 Parameter DWELL_FRAMES, default 15, frames held at each turnaround.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 resetN  input  1  synchronous reset, active-high (asserted = 1) despite the name.
REQ-009 startOfFrame  input  1  one-cycle pulse per frame; sole motion time base.
REQ-010 enable  input  1  1 = rope runs, 0 = rope parks in IDLE.
REQ-011 freeze  input  1  1 = player hanging on rope; all motion and counting suspended.
REQ-012 speed_sel  input  2  speed code, sampled only at the events in REQ-018.
REQ-013 topLeftX  output  11 signed  rope left edge, pixels.
REQ-014 topLeftY  output  11 signed  rope top, pixels.
REQ-015 widthX  output  11 signed  rope width, pixels.
REQ-016 moving  output  1  1 in SWING_R or SWING_L and freeze = 0.
REQ-017 dir_right  output  1  1 when current or next swing is rightward.

Function
REQ-018 Speed latch: speed_sel is registered on leaving IDLE and on each DWELL exit; codes 0/1/2/3 = 32/64/128/256 fixed-point units per frame (128 units = 1 pixel).
REQ-019 Position is held internally in fixed point (pixels x 128, 32-bit signed); topLeftX = pos / 128 truncated; widthX = (INITIAL_X + INITIAL_WIDTH) - topLeftX, so the right edge stays fixed at 573 with defaults.
REQ-020 topLeftY is the constant INITIAL_Y.
REQ-021 States: IDLE, SWING_R, DWELL_R, SWING_L, DWELL_L.
REQ-022 IDLE: position held; on enable = 1 and startOfFrame = 1, go to SWING_R (dir_right = 1) and latch speed; no movement in that frame.
REQ-023 SWING_R: on each startOfFrame, pos += speed; if result >= MAX_X x 128, clamp pos to MAX_X x 128, clear dwell counter, go to DWELL_R.
REQ-024 SWING_L: on each startOfFrame, pos -= speed; if result <= MIN_X x 128, clamp pos to MIN_X x 128, clear dwell counter, go to DWELL_L.
REQ-025 DWELL_R / DWELL_L: dwell counter increments per startOfFrame; when it reaches DWELL_FRAMES - 1, the state becomes SWING_L / SWING_R respectively, and the block latches speed and toggles dir_right on that same frame.
REQ-026 Position never leaves [MIN_X x 128, MAX_X x 128] once clamped; no overshoot for any speed code.
REQ-027 freeze = 1: state, position, dwell counter and latched speed held; startOfFrame ignored; motion resumes on the first startOfFrame after freeze falls.
REQ-028 freeze has priority over boundary detection and dwell expiry in the same cycle.
REQ-029 enable = 0 in any state: on next clk go to IDLE, position held where it is (not recentred); dir_right set to 1.
REQ-030 freeze = 1 with enable = 0: enable rule (REQ-029) wins.
REQ-031 All outputs are registered; a startOfFrame update is visible on outputs the cycle after the pulse.
REQ-032 No state change occurs on cycles without startOfFrame, except REQ-029.

Reset
REQ-033 resetN = 1 at any clk edge, including mid-swing or mid-dwell, forces IDLE, pos = INITIAL_X x 128, dwell counter 0, latched speed 128, dir_right 1.
REQ-034 Output values during and after reset: topLeftX 450, topLeftY 226, widthX 123, moving 0, dir_right 1.

Verification
REQ-035 Reset, enable = 1, speed_sel = 2, then 95 frames -> 1st frame enters SWING_R; after the 94th moving frame topLeftX = 544, widthX = 29, state DWELL_R.
REQ-036 Continue 15 frames -> leaves DWELL_R, dir_right = 0; next frame topLeftX = 543, widthX = 30.
REQ-037 speed_sel = 3 from 450 -> topLeftX 452, 454, ... 544 (47 frames) and clamps at exactly 544, never 546.
REQ-038 freeze = 1 mid-swing at topLeftX = 500 for 20 frames -> topLeftX stays 500, moving = 0; after release the next frame gives 501 (speed code 2).
REQ-039 enable falls at topLeftX = 520, then rises -> IDLE holds 520; SWING_R restarts from 520 rightward.
REQ-040 resetN pulse during DWELL_L -> next cycle topLeftX 450, widthX 123, moving 0, state IDLE.
